// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// One operand bit is processed per cycle; HI/LO change only in FIX (or MTHI/MTLO in IDLE).
module hilo_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    input  logic             i_hilo_read,
    input  logic [1:0]       i_hilo_write,
    input  logic [WIDTH-1:0] i_write_data,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

    state_t               r_state, w_next;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a, r_b;
    logic [WIDTH-1:0]     r_opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0]   r_prod;      // product; low half doubles as dividend/quotient
    logic [WIDTH-1:0]     r_rem;
    logic [CW-1:0]        r_cnt;
    logic                 r_sign_q, r_sign_r, r_dbz;
    logic [WIDTH-1:0]     r_hi, r_lo;
    logic                 r_done, r_dbz_pulse;

    logic                 w_is_div, w_signed, w_zero_div;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_sum, w_shrem;
    logic [WIDTH-1:0]     w_diff;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

    assign w_is_div   = r_op[1];
    assign w_signed   = ~r_op[0];
    assign w_zero_div = w_is_div && (r_b == '0);
    assign w_mag_a    = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_mag_b    = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

    // Shift-add step: add multiplicand when the current multiplier bit is set.
    assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                     (r_prod[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    // Restoring-division step on the WIDTH+1-bit shifted partial remainder.
    assign w_shrem = {r_rem, r_prod[WIDTH-1]};
    assign w_ge    = (w_shrem >= {1'b0, r_opnd});
    assign w_diff  = WIDTH'(w_shrem - {1'b0, r_opnd});

    assign w_prod_fix = r_sign_q ? -r_prod : r_prod;
    assign w_quo_fix  = r_sign_q ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    assign w_rem_fix  = r_sign_r ? -r_rem : r_rem;

    assign o_busy        = (r_state != S_IDLE);
    assign o_stall       = o_busy & (i_start | i_hilo_read | (|i_hilo_write));
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz_pulse;
    assign o_hi          = r_hi;
    assign o_lo          = r_lo;

    // State register
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_PREP;
            S_PREP:  w_next = w_zero_div ? S_FIX : S_RUN;
            S_RUN:   if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, sign fix-up and HI/LO ownership
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op <= '0; r_a <= '0; r_b <= '0; r_opnd <= '0; r_prod <= '0; r_rem <= '0;
            r_cnt <= '0; r_sign_q <= 1'b0; r_sign_r <= 1'b0; r_dbz <= 1'b0;
            r_hi <= '0; r_lo <= '0; r_done <= 1'b0; r_dbz_pulse <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // A Start takes priority over a same-cycle MTHI/MTLO.
                        r_op <= i_op;
                        r_a  <= i_operand_a;
                        r_b  <= i_operand_b;
                    end else begin
                        if (i_hilo_write[1]) r_hi <= i_write_data;
                        if (i_hilo_write[0]) r_lo <= i_write_data;
                    end
                end
                S_PREP: begin
                    r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                    r_prod   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    r_sign_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sign_r <= w_signed & r_a[WIDTH-1];
                    r_dbz    <= w_zero_div;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_is_div) begin
                        r_rem               <= w_ge ? w_diff : w_shrem[WIDTH-1:0];
                        r_prod[WIDTH-1:0]   <= {r_prod[WIDTH-2:0], w_ge};
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_done      <= 1'b1;
                    r_dbz_pulse <= r_dbz;
                    if (r_dbz) begin
                        r_hi <= r_a;
                        r_lo <= '1;
                    end else if (w_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
